// File: rtl/ball_bounce_engine.sv
// Single-clock bouncing-ball engine: per-frame position/velocity update on a
// synchronously detected vsync rise, four-wall bounce with clamping, serve/pause, pixel mask.
module ball_bounce_engine #(
    parameter int WIDTH     = 9,
    parameter int VEL_W     = 4,
    parameter int BALL_SIZE = 4,
    parameter int H_MAX     = 256,
    parameter int V_MAX     = 240,
    parameter int X_INIT    = 128,
    parameter int Y_INIT    = 128,
    parameter int DX_INIT   = -2,
    parameter int DY_INIT   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] hpos,
    input  logic [WIDTH-1:0] vpos,
    input  logic             vsync,
    input  logic             display_on,
    input  logic             enable,
    input  logic             serve,
    input  logic [WIDTH-1:0] serve_x,
    input  logic [WIDTH-1:0] serve_y,
    input  logic [VEL_W-1:0] serve_dx,
    input  logic [VEL_W-1:0] serve_dy,
    output logic [WIDTH-1:0] ball_x,
    output logic [WIDTH-1:0] ball_y,
    output logic [VEL_W-1:0] ball_dx,
    output logic [VEL_W-1:0] ball_dy,
    output logic             hit_h,
    output logic             hit_v,
    output logic             ball_gfx
);

    localparam int EW    = WIDTH + 2;
    localparam int X_MAX = H_MAX - BALL_SIZE;
    localparam int Y_MAX = V_MAX - BALL_SIZE;

    localparam logic [WIDTH-1:0]        X_MAX_W = WIDTH'(X_MAX);
    localparam logic [WIDTH-1:0]        Y_MAX_W = WIDTH'(Y_MAX);
    localparam logic signed [EW-1:0]    X_MAX_E = EW'(X_MAX);
    localparam logic signed [EW-1:0]    Y_MAX_E = EW'(Y_MAX);
    localparam logic [WIDTH-1:0]        SIZE_W  = WIDTH'(BALL_SIZE);
    localparam logic [VEL_W-1:0]        VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic [VEL_W-1:0]        VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        STEP_X,
        STEP_Y
    } state_t;

    state_t state, next_state;

    logic vsync_d;
    logic tick;

    assign tick = vsync & ~vsync_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tick && enable) next_state = STEP_X;
            STEP_X:  next_state = STEP_Y;
            STEP_Y:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (serve) next_state = IDLE;
    end

    // One adder serves both axes; STEP_Y selects the y operands.
    logic [WIDTH-1:0]     pos_cur;
    logic [VEL_W-1:0]     vel_cur;
    logic [VEL_W-1:0]     vel_neg;
    logic signed [EW-1:0] pos_ext;
    logic signed [EW-1:0] vel_ext;
    logic signed [EW-1:0] npos;
    logic signed [EW-1:0] lim;
    logic                 under;
    logic                 over;

    always_comb begin
        pos_cur = ball_x;
        vel_cur = ball_dx;
        lim     = X_MAX_E;
        if (state == STEP_Y) begin
            pos_cur = ball_y;
            vel_cur = ball_dy;
            lim     = Y_MAX_E;
        end
        pos_ext = $signed({2'b00, pos_cur});
        vel_ext = $signed({{(EW-VEL_W){vel_cur[VEL_W-1]}}, vel_cur});
        npos    = pos_ext + vel_ext;
        under   = npos[EW-1];
        over    = npos > lim;
        vel_neg = (vel_cur == VEL_MIN) ? VEL_MAX : ('0 - vel_cur);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_d <= 1'b0;
            ball_x  <= WIDTH'(X_INIT);
            ball_y  <= WIDTH'(Y_INIT);
            ball_dx <= VEL_W'(DX_INIT);
            ball_dy <= VEL_W'(DY_INIT);
            hit_h   <= 1'b0;
            hit_v   <= 1'b0;
        end else begin
            vsync_d <= vsync;
            hit_h   <= 1'b0;
            hit_v   <= 1'b0;
            if (serve) begin
                ball_x  <= (serve_x > X_MAX_W) ? X_MAX_W : serve_x;
                ball_y  <= (serve_y > Y_MAX_W) ? Y_MAX_W : serve_y;
                ball_dx <= serve_dx;
                ball_dy <= serve_dy;
            end else if (state == STEP_X) begin
                if (under) begin
                    ball_x  <= '0;
                    ball_dx <= vel_neg;
                    hit_h   <= 1'b1;
                end else if (over) begin
                    ball_x  <= X_MAX_W;
                    ball_dx <= vel_neg;
                    hit_h   <= 1'b1;
                end else begin
                    ball_x  <= npos[WIDTH-1:0];
                end
            end else if (state == STEP_Y) begin
                if (under) begin
                    ball_y  <= '0;
                    ball_dy <= vel_neg;
                    hit_v   <= 1'b1;
                end else if (over) begin
                    ball_y  <= Y_MAX_W;
                    ball_dy <= vel_neg;
                    hit_v   <= 1'b1;
                end else begin
                    ball_y  <= npos[WIDTH-1:0];
                end
            end
        end
    end

    // Modular differences make pixels left of / above the ball wrap to large values.
    logic [WIDTH-1:0] hd;
    logic [WIDTH-1:0] vd;

    assign hd = hpos - ball_x;
    assign vd = vpos - ball_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ball_gfx <= 1'b0;
        end else begin
            ball_gfx <= display_on & (hd < SIZE_W) & (vd < SIZE_W);
        end
    end

endmodule

// File: tb/tb_ball_bounce_engine.sv
// Directed bench for ball_bounce_engine: motion, wall bounces, serve, pause/gfx, reset.
module tb_ball_bounce_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] hpos, vpos;
    logic       vsync, display_on, enable, serve;
    logic [8:0] serve_x, serve_y;
    logic [3:0] serve_dx, serve_dy;
    logic [8:0] ball_x, ball_y;
    logic [3:0] ball_dx, ball_dy;
    logic       hit_h, hit_v, ball_gfx;

    int total = 0;
    int bad   = 0;

    ball_bounce_engine dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .vsync(vsync),
        .display_on(display_on), .enable(enable), .serve(serve),
        .serve_x(serve_x), .serve_y(serve_y), .serve_dx(serve_dx), .serve_dy(serve_dy),
        .ball_x(ball_x), .ball_y(ball_y), .ball_dx(ball_dx), .ball_dy(ball_dy),
        .hit_h(hit_h), .hit_v(hit_v), .ball_gfx(ball_gfx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_serve(input logic [8:0] x, input logic [8:0] y,
                            input logic [3:0] dx, input logic [3:0] dy);
        serve_x = x; serve_y = y; serve_dx = dx; serve_dy = dy;
        serve = 1'b1;
        step();
        serve = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; vsync = 1'b0; display_on = 1'b0; enable = 1'b1; serve = 1'b0;
        hpos = '0; vpos = '0; serve_x = '0; serve_y = '0; serve_dx = '0; serve_dy = '0;
        step(); step();
        total++; if (ball_x !== 9'd128) begin bad++; $display("FAIL rst_x act=%0d req=128", ball_x); end
        total++; if (ball_y !== 9'd128) begin bad++; $display("FAIL rst_y act=%0d req=128", ball_y); end
        total++; if (ball_dx !== 4'hE) begin bad++; $display("FAIL rst_dx act=%h req=e", ball_dx); end
        total++; if (ball_dy !== 4'h2) begin bad++; $display("FAIL rst_dy act=%h req=2", ball_dy); end
        total++; if ({hit_h, hit_v, ball_gfx} !== 3'b000) begin bad++; $display("FAIL rst_flags act=%b req=000", {hit_h, hit_v, ball_gfx}); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_move();
        vsync = 1'b1;
        step();
        total++; if (ball_x !== 9'd128) begin bad++; $display("FAIL mv_t1_x act=%0d req=128", ball_x); end
        step();
        total++; if (ball_x !== 9'd126) begin bad++; $display("FAIL mv_t2_x act=%0d req=126", ball_x); end
        total++; if (ball_y !== 9'd128) begin bad++; $display("FAIL mv_t2_y act=%0d req=128", ball_y); end
        total++; if (hit_h !== 1'b0) begin bad++; $display("FAIL mv_t2_hit act=%b req=0", hit_h); end
        step();
        total++; if (ball_y !== 9'd130) begin bad++; $display("FAIL mv_t3_y act=%0d req=130", ball_y); end
        total++; if (hit_v !== 1'b0) begin bad++; $display("FAIL mv_t3_hit act=%b req=0", hit_v); end
        step(); step();
        total++; if (ball_x !== 9'd126 || ball_y !== 9'd130) begin bad++; $display("FAIL mv_hold act=%0d,%0d req=126,130", ball_x, ball_y); end
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        step(); step(); step();
        total++; if (ball_x !== 9'd124 || ball_y !== 9'd132) begin bad++; $display("FAIL mv2 act=%0d,%0d req=124,132", ball_x, ball_y); end
        total++; if (ball_dx !== 4'hE || ball_dy !== 4'h2) begin bad++; $display("FAIL mv2_vel act=%h,%h req=e,2", ball_dx, ball_dy); end
        vsync = 1'b0;
        step();
    endtask

    task automatic test_bounce_x();
        do_serve(9'd2, 9'd100, 4'hD, 4'h0);
        total++; if (ball_x !== 9'd2 || ball_dx !== 4'hD) begin bad++; $display("FAIL bx_serve act=%0d,%h req=2,d", ball_x, ball_dx); end
        vsync = 1'b1;
        step();
        total++; if (hit_h !== 1'b0) begin bad++; $display("FAIL bx_t1_hit act=%b req=0", hit_h); end
        step();
        total++; if (ball_x !== 9'd0 || ball_dx !== 4'h3) begin bad++; $display("FAIL bx_left act=%0d,%h req=0,3", ball_x, ball_dx); end
        total++; if (hit_h !== 1'b1) begin bad++; $display("FAIL bx_hit act=%b req=1", hit_h); end
        step();
        total++; if (hit_h !== 1'b0) begin bad++; $display("FAIL bx_hit_off act=%b req=0", hit_h); end
        total++; if (ball_y !== 9'd100 || hit_v !== 1'b0) begin bad++; $display("FAIL bx_dy0 act=%0d,%b req=100,0", ball_y, hit_v); end
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        step(); step();
        total++; if (ball_x !== 9'd3 || hit_h !== 1'b0) begin bad++; $display("FAIL bx_next act=%0d,%b req=3,0", ball_x, hit_h); end
        vsync = 1'b0;
        step(); step();
        do_serve(9'd250, 9'd100, 4'h3, 4'h0);
        vsync = 1'b1;
        step(); step();
        total++; if (ball_x !== 9'd252 || ball_dx !== 4'hD || hit_h !== 1'b1) begin bad++; $display("FAIL bx_right act=%0d,%h,%b req=252,d,1", ball_x, ball_dx, hit_h); end
        vsync = 1'b0;
        step(); step();
        do_serve(9'd2, 9'd100, 4'h8, 4'h0);
        vsync = 1'b1;
        step(); step();
        total++; if (ball_x !== 9'd0 || ball_dx !== 4'h7) begin bad++; $display("FAIL bx_sat act=%0d,%h req=0,7", ball_x, ball_dx); end
        vsync = 1'b0;
        step(); step();
    endtask

    task automatic test_bounce_y();
        do_serve(9'd50, 9'd234, 4'h0, 4'h3);
        vsync = 1'b1;
        step(); step();
        total++; if (ball_x !== 9'd50 || hit_h !== 1'b0) begin bad++; $display("FAIL by_x act=%0d,%b req=50,0", ball_x, hit_h); end
        step();
        total++; if (ball_y !== 9'd236 || ball_dy !== 4'hD) begin bad++; $display("FAIL by_bottom act=%0d,%h req=236,d", ball_y, ball_dy); end
        total++; if (hit_v !== 1'b1) begin bad++; $display("FAIL by_hit act=%b req=1", hit_v); end
        step();
        total++; if (hit_v !== 1'b0) begin bad++; $display("FAIL by_hit_off act=%b req=0", hit_v); end
        vsync = 1'b0;
        step();
        do_serve(9'd50, 9'd233, 4'h0, 4'h3);
        vsync = 1'b1;
        step(); step(); step();
        total++; if (ball_y !== 9'd236 || ball_dy !== 4'h3 || hit_v !== 1'b0) begin bad++; $display("FAIL by_exact act=%0d,%h,%b req=236,3,0", ball_y, ball_dy, hit_v); end
        vsync = 1'b0;
        step();
        do_serve(9'd300, 9'd250, 4'h1, 4'h1);
        total++; if (ball_x !== 9'd252 || ball_y !== 9'd236) begin bad++; $display("FAIL serve_clamp act=%0d,%0d req=252,236", ball_x, ball_y); end
    endtask

    task automatic test_pause_gfx();
        do_serve(9'd20, 9'd30, 4'h1, 4'h1);
        enable = 1'b0;
        for (int f = 0; f < 3; f++) begin
            vsync = 1'b1;
            for (int c = 0; c < 4; c++) begin
                step();
                total++; if (hit_h !== 1'b0 || hit_v !== 1'b0) begin bad++; $display("FAIL pause_hit act=%b%b req=00", hit_h, hit_v); end
            end
            vsync = 1'b0;
            step();
        end
        total++; if (ball_x !== 9'd20 || ball_y !== 9'd30 || ball_dx !== 4'h1 || ball_dy !== 4'h1) begin bad++; $display("FAIL pause_hold act=%0d,%0d,%h,%h req=20,30,1,1", ball_x, ball_y, ball_dx, ball_dy); end
        hpos = 9'd20; vpos = 9'd30; display_on = 1'b0;
        step();
        total++; if (ball_gfx !== 1'b0) begin bad++; $display("FAIL gfx_dispoff act=%b req=0", ball_gfx); end
        display_on = 1'b1;
        #1;
        total++; if (ball_gfx !== 1'b0) begin bad++; $display("FAIL gfx_lag act=%b req=0", ball_gfx); end
        step();
        total++; if (ball_gfx !== 1'b1) begin bad++; $display("FAIL gfx_corner act=%b req=1", ball_gfx); end
        hpos = 9'd23; vpos = 9'd33;
        step();
        total++; if (ball_gfx !== 1'b1) begin bad++; $display("FAIL gfx_far act=%b req=1", ball_gfx); end
        hpos = 9'd24;
        step();
        total++; if (ball_gfx !== 1'b0) begin bad++; $display("FAIL gfx_right act=%b req=0", ball_gfx); end
        hpos = 9'd19; vpos = 9'd31;
        step();
        total++; if (ball_gfx !== 1'b0) begin bad++; $display("FAIL gfx_left act=%b req=0", ball_gfx); end
        hpos = 9'd21; vpos = 9'd34;
        step();
        total++; if (ball_gfx !== 1'b0) begin bad++; $display("FAIL gfx_below act=%b req=0", ball_gfx); end
        display_on = 1'b0; hpos = '0; vpos = '0;
        enable = 1'b1;
        step();
    endtask

    task automatic test_serve_tick();
        vsync = 1'b1;
        do_serve(9'd1, 9'd70, 4'hD, 4'hF);
        total++; if (ball_x !== 9'd1 || ball_y !== 9'd70 || ball_dx !== 4'hD || ball_dy !== 4'hF) begin bad++; $display("FAIL st_load act=%0d,%0d,%h,%h req=1,70,d,f", ball_x, ball_y, ball_dx, ball_dy); end
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (ball_x !== 9'd1 || ball_y !== 9'd70 || hit_h !== 1'b0 || hit_v !== 1'b0) begin bad++; $display("FAIL st_nomove act=%0d,%0d,%b%b req=1,70,00", ball_x, ball_y, hit_h, hit_v); end
        end
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        step();
        do_serve(9'd80, 9'd90, 4'h1, 4'h1);
        total++; if (ball_x !== 9'd80 || ball_dx !== 4'h1 || hit_h !== 1'b0) begin bad++; $display("FAIL st_mid act=%0d,%h,%b req=80,1,0", ball_x, ball_dx, hit_h); end
        step();
        total++; if (ball_y !== 9'd90 || ball_dy !== 4'h1 || hit_v !== 1'b0) begin bad++; $display("FAIL st_mid_y act=%0d,%h,%b req=90,1,0", ball_y, ball_dy, hit_v); end
        step();
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        step(); step(); step();
        total++; if (ball_x !== 9'd81 || ball_y !== 9'd91) begin bad++; $display("FAIL st_after act=%0d,%0d req=81,91", ball_x, ball_y); end
        vsync = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        do_serve(9'd0, 9'd100, 4'hF, 4'h1);
        vsync = 1'b1;
        step(); step();
        total++; if (ball_x !== 9'd0 || ball_dx !== 4'h1 || hit_h !== 1'b1) begin bad++; $display("FAIL rm_pre act=%0d,%h,%b req=0,1,1", ball_x, ball_dx, hit_h); end
        reset = 1'b0;
        #1;
        total++; if (ball_x !== 9'd128 || ball_y !== 9'd128 || ball_dx !== 4'hE || ball_dy !== 4'h2) begin bad++; $display("FAIL rm_async act=%0d,%0d,%h,%h req=128,128,e,2", ball_x, ball_y, ball_dx, ball_dy); end
        total++; if ({hit_h, hit_v, ball_gfx} !== 3'b000) begin bad++; $display("FAIL rm_flags act=%b req=000", {hit_h, hit_v, ball_gfx}); end
        vsync = 1'b0;
        step(); step();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) step();
        total++; if (ball_x !== 9'd128 || ball_y !== 9'd128 || hit_h !== 1'b0 || hit_v !== 1'b0) begin bad++; $display("FAIL rm_idle act=%0d,%0d,%b%b req=128,128,00", ball_x, ball_y, hit_h, hit_v); end
        vsync = 1'b1;
        step(); step(); step();
        total++; if (ball_x !== 9'd126 || ball_y !== 9'd130) begin bad++; $display("FAIL rm_move act=%0d,%0d req=126,130", ball_x, ball_y); end
        vsync = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_move();
        test_bounce_x();
        test_bounce_y();
        test_pause_gfx();
        test_serve_tick();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
